// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter: channel id type and the upper bound on channel count.
package pipeline_types;

    localparam int NUM_CH_MAX = 8;

    typedef logic [$clog2(NUM_CH_MAX)-1:0] arb_ch_id_t;

    function automatic arb_ch_id_t ch_wrap_inc(input arb_ch_id_t id, input int num_ch);
        if (int'(id) >= num_ch - 1) begin
            return '0;
        end
        return id + arb_ch_id_t'(1);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Upstream channel bus plus downstream cache handshake. The master modport is the arbiter's view;
// the slave modport is the environment (requesting channels and cache).
interface mem_req_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]                 up_valid;
    logic [NUM_CH-1:0]                 up_op;
    logic [NUM_CH-1:0][31:0]           up_addr;
    logic [NUM_CH-1:0][DATA_W/8-1:0]   up_wstrb;
    logic [NUM_CH-1:0][DATA_W-1:0]     up_wdata;
    logic [NUM_CH-1:0]                 up_uncache;
    logic [NUM_CH-1:0]                 up_addr_ok;
    logic [NUM_CH-1:0]                 up_data_ok;
    logic [DATA_W-1:0]                 up_rdata;

    logic                              dn_valid;
    logic                              dn_op;
    logic [31:0]                       dn_addr;
    logic [DATA_W/8-1:0]               dn_wstrb;
    logic [DATA_W-1:0]                 dn_wdata;
    logic                              dn_uncache;
    logic                              dn_addr_ok;
    logic                              dn_data_ok;
    logic [DATA_W-1:0]                 dn_rdata;

    modport master (
        input  up_valid, up_op, up_addr, up_wstrb, up_wdata, up_uncache,
        output up_addr_ok, up_data_ok, up_rdata,
        output dn_valid, dn_op, dn_addr, dn_wstrb, dn_wdata, dn_uncache,
        input  dn_addr_ok, dn_data_ok, dn_rdata
    );

    modport slave (
        output up_valid, up_op, up_addr, up_wstrb, up_wdata, up_uncache,
        input  up_addr_ok, up_data_ok, up_rdata,
        input  dn_valid, dn_op, dn_addr, dn_wstrb, dn_wdata, dn_uncache,
        output dn_addr_ok, dn_data_ok, dn_rdata
    );

endinterface

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order queue of granted channel ids; supports push and pop in the same cycle.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rptr];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of NUM_CH memory request channels onto one cache port, with in-order response routing.
// Define MEM_REQ_ARB_STATS_EN to add per-channel grant counters and a full-stall cycle counter.
module mem_req_arbiter
    import pipeline_types::*;
#(
    parameter int NUM_CH          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_req_arbiter_if.master       bus,
    output logic                    err_unexp_rsp
`ifdef MEM_REQ_ARB_STATS_EN
    ,
    output logic [NUM_CH-1:0][31:0] grant_cnt,
    output logic [31:0]             full_stall_cnt
`endif
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_ch_id_t       r_prio_ptr;
    arb_ch_id_t       r_lock_id;
    logic             r_lock_vld;
    logic             r_err_unexp_rsp;

    arb_ch_id_t       w_rr_id;
    arb_ch_id_t       w_gnt_id;
    arb_ch_id_t       w_head_id;
    logic             w_rr_vld;
    logic             w_lock_hit;
    logic             w_gnt_vld;
    logic             w_dn_valid;
    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;

    // Round-robin search upward from r_prio_ptr, wrapping at NUM_CH.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_id  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_rr_vld && bus.up_valid[c] &&
                    ((int'(r_prio_ptr) + k == c) || (int'(r_prio_ptr) + k == c + NUM_CH))) begin
                    w_rr_vld = 1'b1;
                    w_rr_id  = arb_ch_id_t'(c);
                end
            end
        end
    end

    always_comb begin
        w_lock_hit = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_lock_vld && r_lock_id == arb_ch_id_t'(c) && bus.up_valid[c]) begin
                w_lock_hit = 1'b1;
            end
        end
    end

    assign w_gnt_vld  = w_lock_hit || w_rr_vld;
    assign w_gnt_id   = w_lock_hit ? r_lock_id : w_rr_id;
    assign w_dn_valid = rst_n && w_gnt_vld && !w_full;
    assign w_accept   = w_dn_valid && bus.dn_addr_ok;
    assign w_pop      = rst_n && bus.dn_data_ok && !w_empty;

    always_comb begin
        bus.dn_op      = 1'b0;
        bus.dn_addr    = '0;
        bus.dn_wstrb   = '0;
        bus.dn_wdata   = '0;
        bus.dn_uncache = 1'b0;
        bus.up_addr_ok = '0;
        bus.up_data_ok = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt_id == arb_ch_id_t'(c)) begin
                bus.dn_op      = bus.up_op[c];
                bus.dn_addr    = bus.up_addr[c];
                bus.dn_wstrb   = bus.up_wstrb[c];
                bus.dn_wdata   = bus.up_wdata[c];
                bus.dn_uncache = bus.up_uncache[c];
                bus.up_addr_ok[c] = w_accept;
            end
            if (w_head_id == arb_ch_id_t'(c)) begin
                bus.up_data_ok[c] = w_pop;
            end
        end
    end

    assign bus.dn_valid  = w_dn_valid;
    assign bus.up_rdata  = bus.dn_rdata;
    assign err_unexp_rsp = r_err_unexp_rsp;

    // A presented-but-stalled request holds the grant until accepted or withdrawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_ptr      <= '0;
            r_lock_vld      <= 1'b0;
            r_lock_id       <= '0;
            r_err_unexp_rsp <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prio_ptr <= ch_wrap_inc(w_gnt_id, NUM_CH);
                r_lock_vld <= 1'b0;
            end else if (w_dn_valid) begin
                r_lock_vld <= 1'b1;
                r_lock_id  <= w_gnt_id;
            end else if (!w_lock_hit) begin
                r_lock_vld <= 1'b0;
            end
            if (bus.dn_data_ok && w_empty) begin
                r_err_unexp_rsp <= 1'b1;
            end
        end
    end

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     ($bits(arb_ch_id_t))
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (w_gnt_id),
        .dout  (w_head_id),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

`ifdef MEM_REQ_ARB_STATS_EN
    logic [NUM_CH-1:0][31:0] r_grant_cnt;
    logic [31:0]             r_full_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt      <= '0;
            r_full_stall_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_accept && w_gnt_id == arb_ch_id_t'(c)) begin
                    r_grant_cnt[c] <= r_grant_cnt[c] + 32'd1;
                end
            end
            if (|bus.up_valid && w_full) begin
                r_full_stall_cnt <= r_full_stall_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt      = r_grant_cnt;
    assign full_stall_cnt = r_full_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: round robin, grant lock, full queue, ordering, unexpected response, reset.
module tb_mem_req_arbiter;
    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic err_unexp_rsp;

    always #5 clk = ~clk;

    mem_req_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

`ifdef MEM_REQ_ARB_STATS_EN
    logic [NUM_CH-1:0][31:0] grant_cnt;
    logic [31:0]             full_stall_cnt;
`endif

    mem_req_arbiter #(
        .NUM_CH          (NUM_CH),
        .MAX_OUTSTANDING (MAX_OUT),
        .DATA_W          (DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .err_unexp_rsp  (err_unexp_rsp)
`ifdef MEM_REQ_ARB_STATS_EN
        ,
        .grant_cnt      (grant_cnt),
        .full_stall_cnt (full_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.up_valid      = '0;
        bus.up_op         = 2'b10;
        bus.up_uncache    = 2'b10;
        bus.up_addr[0]    = 32'h0000_1000;
        bus.up_addr[1]    = 32'h0000_2000;
        bus.up_wstrb[0]   = 4'hF;
        bus.up_wstrb[1]   = 4'h3;
        bus.up_wdata[0]   = 32'h1111_1111;
        bus.up_wdata[1]   = 32'h2222_2222;
        bus.dn_addr_ok    = 1'b0;
        bus.dn_data_ok    = 1'b0;
        bus.dn_rdata      = '0;

        // Requests pending while in reset must not leak out.
        #1;
        bus.up_valid   = 2'b11;
        bus.dn_data_ok = 1'b1;
        settle();
        check("rst_dn_valid",   bus.dn_valid,   1'b0);
        check("rst_up_addr_ok", bus.up_addr_ok, 2'b00);
        check("rst_up_data_ok", bus.up_data_ok, 2'b00);
        check("rst_err",        err_unexp_rsp,  1'b0);

        // Round robin with both channels valid.
        tick();
        rst_n          = 1'b1;
        bus.dn_data_ok = 1'b0;
        bus.dn_addr_ok = 1'b1;
        settle();
        check("rr0_addr_ok", bus.up_addr_ok, 2'b01);
        check("rr0_addr",    bus.dn_addr,    32'h1000);
        check("rr0_op",      bus.dn_op,      1'b0);
        tick(); settle();
        check("rr1_addr_ok", bus.up_addr_ok, 2'b10);
        check("rr1_addr",    bus.dn_addr,    32'h2000);
        check("rr1_op",      bus.dn_op,      1'b1);
        check("rr1_wstrb",   bus.dn_wstrb,   4'h3);
        check("rr1_wdata",   bus.dn_wdata,   32'h2222_2222);
        check("rr1_uncache", bus.dn_uncache, 1'b1);
        tick(); settle();
        check("rr2_addr_ok", bus.up_addr_ok, 2'b01);
        check("rr2_addr",    bus.dn_addr,    32'h1000);

        // Drain ch0, ch1, ch0.
        tick();
        bus.up_valid   = 2'b00;
        bus.dn_data_ok = 1'b1;
        bus.dn_rdata   = 32'h100;
        settle();
        check("rsp0_data_ok", bus.up_data_ok, 2'b01);
        check("rsp0_rdata",   bus.up_rdata,   32'h100);
        check("idle_dn_valid", bus.dn_valid,  1'b0);
        tick(); bus.dn_rdata = 32'h200; settle();
        check("rsp1_data_ok", bus.up_data_ok, 2'b10);
        check("rsp1_rdata",   bus.up_rdata,   32'h200);
        tick(); bus.dn_rdata = 32'h300; settle();
        check("rsp2_data_ok", bus.up_data_ok, 2'b01);

        // One ch1 acceptance moves the pointer back to ch0.
        tick();
        bus.dn_data_ok = 1'b0;
        bus.up_valid   = 2'b10;
        settle();
        check("pre_addr_ok", bus.up_addr_ok, 2'b10);

        // ch1 presented under backpressure, then ch0 joins: grant must stay on ch1.
        tick();
        bus.dn_addr_ok = 1'b0;
        settle();
        check("bp_dn_valid", bus.dn_valid,   1'b1);
        check("bp_addr",     bus.dn_addr,    32'h2000);
        check("bp_addr_ok",  bus.up_addr_ok, 2'b00);
        tick();
        bus.up_valid = 2'b11;
        settle();
        check("lock0_addr", bus.dn_addr, 32'h2000);
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            check("lock_addr",    bus.dn_addr,    32'h2000);
            check("lock_addr_ok", bus.up_addr_ok, 2'b00);
        end
        tick();
        bus.dn_addr_ok = 1'b1;
        settle();
        check("lock_accept_ok",   bus.up_addr_ok, 2'b10);
        check("lock_accept_addr", bus.dn_addr,    32'h2000);
        tick(); settle();
        check("after_lock_ok", bus.up_addr_ok, 2'b01);
        tick(); settle();
        check("fill_ok", bus.up_addr_ok, 2'b10);

        // Queue holds ch1, ch1, ch0, ch1: full.
        tick(); settle();
        check("full_dn_valid", bus.dn_valid,   1'b0);
        check("full_addr_ok",  bus.up_addr_ok, 2'b00);
        bus.dn_data_ok = 1'b1;
        bus.dn_rdata   = 32'h9;
        settle();
        check("full_pop_data_ok", bus.up_data_ok, 2'b10);
        check("full_pop_rdata",   bus.up_rdata,   32'h9);
        check("full_pop_dn_valid", bus.dn_valid,  1'b0);
        tick();
        bus.dn_data_ok = 1'b0;
        settle();
        check("refill_dn_valid", bus.dn_valid,   1'b1);
        check("refill_addr_ok",  bus.up_addr_ok, 2'b01);

        // Queue now ch1, ch0, ch1, ch0: responses come back in that order.
        tick();
        bus.up_valid   = 2'b00;
        bus.dn_data_ok = 1'b1;
        bus.dn_rdata   = 32'hA;
        settle();
        check("ord0_data_ok", bus.up_data_ok, 2'b10);
        check("ord0_rdata",   bus.up_rdata,   32'hA);
        tick(); bus.dn_rdata = 32'hB; settle();
        check("ord1_data_ok", bus.up_data_ok, 2'b01);
        check("ord1_rdata",   bus.up_rdata,   32'hB);
        tick(); bus.dn_rdata = 32'hC; settle();
        check("ord2_data_ok", bus.up_data_ok, 2'b10);
        check("ord2_rdata",   bus.up_rdata,   32'hC);
        tick(); bus.dn_rdata = 32'hD; settle();
        check("ord3_data_ok", bus.up_data_ok, 2'b01);

        // Response with nothing outstanding.
        tick(); bus.dn_rdata = 32'hE; settle();
        check("unexp_data_ok", bus.up_data_ok, 2'b00);
        check("unexp_err_pre", err_unexp_rsp,  1'b0);
        tick();
        bus.dn_data_ok = 1'b0;
        settle();
        check("unexp_err", err_unexp_rsp, 1'b1);

        // Push and pop in one cycle keep the count.
        bus.up_valid = 2'b01;
        settle();
        check("pp_addr_ok0", bus.up_addr_ok, 2'b01);
        tick();
        bus.dn_data_ok = 1'b1;
        bus.dn_rdata   = 32'h55;
        settle();
        check("pp_data_ok", bus.up_data_ok, 2'b01);
        check("pp_addr_ok", bus.up_addr_ok, 2'b01);
        check("pp_rdata",   bus.up_rdata,   32'h55);
        tick();
        bus.dn_data_ok = 1'b0;
        settle();
        check("pp_count", dut.u_id_fifo.count, 3'd1);

        // Reset in the middle of traffic.
        tick();
        rst_n          = 1'b0;
        bus.dn_data_ok = 1'b1;
        settle();
        check("mrst_dn_valid",   bus.dn_valid,        1'b0);
        check("mrst_addr_ok",    bus.up_addr_ok,      2'b00);
        check("mrst_data_ok",    bus.up_data_ok,      2'b00);
        check("mrst_err",        err_unexp_rsp,       1'b0);
        check("mrst_count",      dut.u_id_fifo.count, 3'd0);
        tick();
        rst_n        = 1'b1;
        bus.up_valid = 2'b00;
        settle();
        check("post_rst_data_ok", bus.up_data_ok, 2'b00);
        tick();
        bus.dn_data_ok = 1'b0;
        settle();
        check("post_rst_err", err_unexp_rsp, 1'b1);

`ifdef MEM_REQ_ARB_STATS_EN
        bus.dn_data_ok = 1'b1;
        bus.up_valid   = 2'b01;
        repeat (5) tick();
        bus.up_valid   = 2'b10;
        repeat (3) tick();
        bus.up_valid   = 2'b00;
        bus.dn_data_ok = 1'b0;
        settle();
        check("stats_grant_ch0", grant_cnt[0], 32'd5);
        check("stats_grant_ch1", grant_cnt[1], 32'd3);
        check("stats_full_stall", full_stall_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 2: number of requesting channels, range 2..8.
REQ-002 The block SHALL take parameter MAX_OUTSTANDING, default 4: accepted but unanswered requests, power of two, range 2..16.
REQ-003 The block SHALL take parameter DATA_W, default 32: width of wdata and rdata; wstrb width is DATA_W/8.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 up_valid  in  NUM_CH  per-channel request valid.
REQ-007 up_op  in  NUM_CH  per-channel op: 0 read, 1 write.
REQ-008 up_addr  in  NUM_CH x 32  per-channel address.
REQ-009 up_wstrb  in  NUM_CH x DATA_W/8  per-channel byte enables.
REQ-010 up_wdata  in  NUM_CH x DATA_W  per-channel write data.
REQ-011 up_uncache  in  NUM_CH  per-channel uncached attribute.
REQ-012 up_addr_ok  out  NUM_CH  request accepted this cycle.
REQ-013 up_data_ok  out  NUM_CH  response for this channel this cycle.
REQ-014 up_rdata  out  DATA_W  response data, broadcast to all channels.
REQ-015 dn_valid, dn_op, dn_addr, dn_wstrb, dn_wdata, dn_uncache  out  1/1/32/DATA_W/8/DATA_W/1  granted request towards the cache.
REQ-016 dn_addr_ok, dn_data_ok  in  1 each; dn_rdata  in  DATA_W: cache handshake, valid/addr_ok/data_ok semantics.
REQ-017 err_unexp_rsp  out  1  sticky: dn_data_ok arrived while no request was outstanding.

Function
REQ-018 The block SHALL select one valid channel per cycle by round-robin, searching upward from prio_ptr with wrap from NUM_CH-1 to 0.
REQ-019 The block SHALL drive the granted channel's fields onto dn_* combinationally, with zero-cycle latency.
REQ-020 A request SHALL be accepted when dn_valid && dn_addr_ok; up_addr_ok SHALL be asserted only for the granted channel in that cycle.
REQ-021 On acceptance, prio_ptr SHALL become (winner+1) mod NUM_CH and the winner id SHALL be pushed into the in-order id queue.
REQ-022 If a granted request is not accepted, the grant SHALL be locked to that channel until it is accepted or its up_valid drops, so the presented request never changes under backpressure.
REQ-023 When the id queue holds MAX_OUTSTANDING entries, dn_valid and all up_addr_ok SHALL be 0, even if a pop occurs in the same cycle.
REQ-024 On dn_data_ok with a non-empty queue, the head SHALL pop and up_data_ok[head] SHALL be 1 that cycle; up_rdata SHALL equal dn_rdata.
REQ-025 A simultaneous push and pop on a non-full queue SHALL leave the count unchanged and keep response order intact.
REQ-026 dn_data_ok on an empty queue SHALL be ignored for routing: all up_data_ok stay 0 and err_unexp_rsp sets.
REQ-027 Responses SHALL be returned strictly in acceptance order; the block does no reordering.

Reset
REQ-028 On rst_n low, asynchronously: prio_ptr=0, grant lock cleared, queue empty, err_unexp_rsp=0.
REQ-029 While rst_n is low, dn_valid, up_addr_ok and up_data_ok SHALL be 0.
REQ-030 Requests in flight at reset SHALL be dropped; any later dn_data_ok for them SHALL be treated as unexpected.

Configuration
REQ-031 With MEM_REQ_ARB_STATS_EN defined, the block SHALL add output grant_cnt (NUM_CH x 32): per-channel accepted-request counters.
REQ-032 With the same macro, the block SHALL add output full_stall_cnt (32): cycles in which any up_valid was 1 and the queue was full.
REQ-033 The stats counters SHALL wrap at 2^32 and reset to 0.
REQ-034 Without MEM_REQ_ARB_STATS_EN, those ports and registers SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-035 Shared package pipeline_types SHALL hold typedef arb_ch_id_t (logic [$clog2(NUM_CH_MAX)-1:0], with NUM_CH_MAX=8) and the constant NUM_CH_MAX.
REQ-036 The id queue SHALL be a sub-module id_fifo (parameters DEPTH and W) with push/pop/full/empty/count and simultaneous push+pop support.

Verification
REQ-037 NUM_CH=2; both channels valid from reset; dn_addr_ok=1 -> grants ch0, ch1, ch0 on successive cycles.
REQ-038 ch1 granted with dn_addr_ok=0 for 3 cycles while ch0 also raises valid -> dn_addr stays ch1's address; ch1 is accepted first.
REQ-039 Four requests accepted with dn_data_ok=0 (MAX_OUTSTANDING=4) -> dn_valid=0; one dn_data_ok -> next cycle one more request is accepted.
REQ-040 Accepted order ch1, ch0, ch1 with dn_rdata 0xA, 0xB, 0xC -> up_data_ok pulses ch1, ch0, ch1 with matching up_rdata.
REQ-041 dn_data_ok with queue empty -> no up_data_ok and err_unexp_rsp=1; rst_n low mid-traffic -> all outputs 0 at once and queue count 0.
REQ-042 With MEM_REQ_ARB_STATS_EN defined, 5 ch0 and 3 ch1 acceptances -> grant_cnt = {3,5}.
